// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA read-side scanout.
// 640x480@60 timing, 160x120 RGB332 frame buffer.
package vga_pkg;

    // Width of the pixel counters (h up to 799, v up to 524).
    localparam int CNT_W = 10;

    // Horizontal timing in pixel ticks.
    localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
    localparam logic [CNT_W-1:0] H_FP     = 10'd16;
    localparam logic [CNT_W-1:0] H_SYNC   = 10'd96;
    localparam logic [CNT_W-1:0] H_BP     = 10'd48;
    localparam logic [CNT_W-1:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines.
    localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
    localparam logic [CNT_W-1:0] V_FP     = 10'd10;
    localparam logic [CNT_W-1:0] V_SYNC   = 10'd2;
    localparam logic [CNT_W-1:0] V_BP     = 10'd33;
    localparam logic [CNT_W-1:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Derived decode points: sync windows are [BEG, END).
    localparam logic [CNT_W-1:0] H_LAST     = H_TOTAL - 10'd1;
    localparam logic [CNT_W-1:0] V_LAST     = V_TOTAL - 10'd1;
    localparam logic [CNT_W-1:0] H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam logic [CNT_W-1:0] H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam logic [CNT_W-1:0] V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam logic [CNT_W-1:0] V_SYNC_END = V_SYNC_BEG + V_SYNC;

    localparam int FB_ROWS = 120;

    // RGB332 field positions inside a frame-buffer word.
    localparam int RGB_R_HI = 7;
    localparam int RGB_R_LO = 5;
    localparam int RGB_G_HI = 4;
    localparam int RGB_G_LO = 2;
    localparam int RGB_B_HI = 1;
    localparam int RGB_B_LO = 0;

    // Registered sync/blank bundle; sync levels are active-low.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_sync_t;

    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    // Colour-bar index for the test pattern: eight bars of 80 pixels.
    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] h);
        return 3'(h / 10'd80);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel counters, sync/blank decode and frame-start pulse for 640x480@60.
// The sync bundle is registered on the pixel tick so it lines up with the
// colour register in the top level (one tick behind the counters).
module vga_timing
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output vga_sync_t        sync_q,
    output logic             frame_start
);

    logic      h_last;
    logic      v_last;
    vga_sync_t sync_d;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);

    // Raster counters: advance one pixel per tick, wrap line and frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Sync/blank decode of the current counter position.
    always_comb begin
        sync_d    = SYNC_IDLE;
        sync_d.hs = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
        sync_d.vs = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
        sync_d.de = active;
    end

    // Sync register: one tick behind the counters, same as the colour path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= SYNC_IDLE;
        end else if (pix_en) begin
            sync_q <= sync_d;
        end
    end

    // One-clk pulse following the tick that wraps (799,524) -> (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last && v_last;
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: reads the frame buffer through RAM port B and drives the DAC.
// Optional build macro VGA_SCANOUT_TEST_PATTERN_EN adds a test_mode input
// that replaces frame-buffer colour with eight vertical colour bars.
//
// The RAM returns data one clk after the address. Because pix_en is never
// high on consecutive clks, mem_q for the current counters is always settled
// by the next tick, which is where the colour register samples it.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int FB_WIDTH    = 160,
    parameter int SCALE_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_en,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [2:0]            vga_r,
    output logic [2:0]            vga_g,
    output logic [1:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_de,
    output logic                  frame_start
);

    logic [CNT_W-1:0]      h_cnt;
    logic [CNT_W-1:0]      v_cnt;
    logic                  active;
    vga_sync_t             sync_q;
    logic [ADDR_WIDTH-1:0] fb_x;
    logic [ADDR_WIDTH-1:0] fb_y;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [2:0]            r_d;
    logic [2:0]            g_d;
    logic [1:0]            b_d;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [2:0]            bar;
`endif

    vga_timing u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .sync_q      (sync_q),
        .frame_start (frame_start)
    );

    // Screen -> buffer coordinates by dropping the scale bits.
    assign fb_x = ADDR_WIDTH'(h_cnt >> SCALE_SHIFT);
    assign fb_y = ADDR_WIDTH'(v_cnt >> SCALE_SHIFT);

    // Row base: 160 = 128 + 32, so two shifted adds replace the multiplier.
    generate
        if (FB_WIDTH == 160) begin : g_row_shift
            assign row_base = (fb_y << 7) + (fb_y << 5);
        end else begin : g_row_mul
            assign row_base = fb_y * ADDR_WIDTH'(FB_WIDTH);
        end
    endgenerate

    // Blanking drives address 0 so the RAM never sees an out-of-range read.
    assign mem_addr = active ? (row_base + fb_x) : '0;

    // Pixel colour for the current counters; black outside the active area.
    always_comb begin
        r_d = mem_q[RGB_R_HI:RGB_R_LO];
        g_d = mem_q[RGB_G_HI:RGB_G_LO];
        b_d = mem_q[RGB_B_HI:RGB_B_LO];
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        bar = bar_index(h_cnt);
        if (test_mode) begin
            r_d = {3{bar[2]}};
            g_d = {3{bar[1]}};
            b_d = {2{bar[0]}};
        end
`endif
        if (!active) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // Colour register: sampled on the tick that moves the counters on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_en) begin
            vga_r <= r_d;
            vga_g <= g_d;
            vga_b <= b_d;
        end
    end

    assign vga_hs = sync_q.hs;
    assign vga_vs = sync_q.vs;
    assign vga_de = sync_q.de;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: tick-count reference model plus a
// table of hand-derived raster positions and directed corner sequences.
`timescale 1ns/1ps
module tb_vga_scanout;

    localparam int HT    = 800;
    localparam int VT    = 525;
    localparam int FRAME = HT * VT;
    localparam int FBN   = 19200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_q = 8'h00;
    logic [2:0]  vga_r, vga_g;
    logic [1:0]  vga_b;
    logic        vga_hs, vga_vs, vga_de, frame_start;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_scanout dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .mem_addr    (mem_addr),
        .mem_q       (mem_q),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .frame_start (frame_start)
    );

    // Frame-buffer RAM, port B: registered read.
    logic [7:0] ram [0:FBN-1];
    always @(posedge clk) mem_q <= (int'(mem_addr) < FBN) ? ram[mem_addr] : 8'h00;

    typedef struct {
        int h; int v; int addr; int de; int hs; int vs;
    } vec_t;
    vec_t tbl [16];

    int checks = 0, errors = 0, nprint = 0;
    int k = 0;          // pixel ticks since reset release
    bit tm_edge = 0;    // test_mode seen by the last tick
    bit tbl_on = 0;
    int idx = 0;
    int hs_run = 0, hs_pulses = 0, vs_run = 0, vs_pulses = 0;
    int fs_count = 0, fs_tick = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (nprint < 40) $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, k);
            nprint++;
        end
    endtask

    function automatic int pos_h(input int kk); return (kk % FRAME) % HT; endfunction
    function automatic int pos_v(input int kk); return (kk % FRAME) / HT; endfunction
    function automatic int is_act(input int h, input int v); return (h < 640 && v < 480) ? 1 : 0; endfunction
    function automatic int exp_addr(input int h, input int v);
        return is_act(h, v) ? (v / 4) * 160 + h / 4 : 0;
    endfunction

    // Compare every DUT output with the model for the current tick count.
    task automatic check_all();
        int ph, pv, er, eg, eb, ehs, evs, ede, bar;
        logic [7:0] d;
        er = 0; eg = 0; eb = 0; ehs = 1; evs = 1; ede = 0;
        chk("mem_addr", int'(mem_addr), exp_addr(pos_h(k), pos_v(k)));
        if (k > 0) begin
            ph  = pos_h(k - 1);
            pv  = pos_v(k - 1);
            ede = is_act(ph, pv);
            ehs = (ph >= 656 && ph < 752) ? 0 : 1;
            evs = (pv >= 490 && pv < 492) ? 0 : 1;
            if (ede == 1) begin
                if (tm_edge) begin
                    bar = ph / 80;
                    er = ((bar >> 2) & 1) * 7;
                    eg = ((bar >> 1) & 1) * 7;
                    eb = (bar & 1) * 3;
                end else begin
                    d  = ram[exp_addr(ph, pv)];
                    er = int'(d[7:5]);
                    eg = int'(d[4:2]);
                    eb = int'(d[1:0]);
                end
            end
        end
        chk("vga_r", int'(vga_r), er);
        chk("vga_g", int'(vga_g), eg);
        chk("vga_b", int'(vga_b), eb);
        chk("vga_hs", int'(vga_hs), ehs);
        chk("vga_vs", int'(vga_vs), evs);
        chk("vga_de", int'(vga_de), ede);
    endtask

    // One pixel tick: pix_en high for one clk, then one idle clk.
    task automatic tick();
        @(negedge clk);
        chk("frame_start_idle", int'(frame_start), 0);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        tm_edge = test_mode;
`endif
        pix_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pix_en = 1'b0;
        k++;
        check_all();
        chk("frame_start", int'(frame_start), (k % FRAME == 0) ? 1 : 0);
        if (frame_start) begin fs_count++; fs_tick = k; end
        if (tbl_on && idx < 16 && pos_h(k) == tbl[idx].h && pos_v(k) == tbl[idx].v) begin
            chk("tbl_addr", int'(mem_addr), tbl[idx].addr);
            chk("tbl_de", int'(vga_de), tbl[idx].de);
            chk("tbl_hs", int'(vga_hs), tbl[idx].hs);
            chk("tbl_vs", int'(vga_vs), tbl[idx].vs);
            idx++;
        end
        if (!vga_hs) begin
            if (hs_run == 0) chk("hs_fall_h", pos_h(k), 657);
            hs_run++;
        end else if (hs_run > 0) begin
            chk("hs_low_len", hs_run, 96);
            hs_pulses++;
            hs_run = 0;
        end
        if (!vga_vs) begin
            if (vs_run == 0) chk("vs_fall_pos", pos_h(k) + pos_v(k) * HT, 1 + 490 * HT);
            vs_run++;
        end else if (vs_run > 0) begin
            chk("vs_low_len", vs_run, 1600);
            vs_pulses++;
            vs_run = 0;
        end
    endtask

    task automatic run_to(input int kk);
        while (k < kk) tick();
    endtask

    initial begin
        // h, v, addr at (h,v), then de/hs/vs for the previous position
        tbl[0]  = '{4,   0,   1,     1, 1, 1};
        tbl[1]  = '{639, 0,   159,   1, 1, 1};
        tbl[2]  = '{640, 0,   0,     1, 1, 1};
        tbl[3]  = '{641, 0,   0,     0, 1, 1};
        tbl[4]  = '{656, 0,   0,     0, 1, 1};
        tbl[5]  = '{657, 0,   0,     0, 0, 1};
        tbl[6]  = '{752, 0,   0,     0, 0, 1};
        tbl[7]  = '{753, 0,   0,     0, 1, 1};
        tbl[8]  = '{0,   4,   160,   0, 1, 1};
        tbl[9]  = '{5,   7,   161,   1, 1, 1};
        tbl[10] = '{639, 479, 19199, 1, 1, 1};
        tbl[11] = '{0,   490, 0,     0, 1, 1};
        tbl[12] = '{1,   490, 0,     0, 1, 0};
        tbl[13] = '{0,   492, 0,     0, 1, 0};
        tbl[14] = '{1,   492, 0,     0, 1, 1};
        tbl[15] = '{0,   0,   0,     0, 1, 1};

        for (int i = 0; i < FBN; i++) ram[i] = 8'($urandom);
        ram[0] = 8'hE0;
        ram[1] = 8'h1C;

        // Power-on reset state.
        repeat (3) @(negedge clk);
        check_all();
        chk("reset_fs", int'(frame_start), 0);
        rst_n = 1'b1;

        // Mid-line asynchronous reset at h=300.
        run_to(300);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("rst_hs", int'(vga_hs), 1);
        chk("rst_vs", int'(vga_vs), 1);
        chk("rst_de", int'(vga_de), 0);
        chk("rst_fs", int'(frame_start), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k = 0; tm_edge = 0; hs_run = 0; vs_run = 0;
        tbl_on = 1;

        // First ticks after release: fresh frame, preloaded pixels.
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin
                chk("post_rst_addr", int'(mem_addr), 0);
                chk("post_rst_hs", int'(vga_hs), 1);
                chk("post_rst_vs", int'(vga_vs), 1);
            end
            chk("line0_r", int'(vga_r), (i <= 4) ? 7 : 0);
            chk("line0_g", int'(vga_g), (i <= 4) ? 0 : 7);
            chk("line0_de", int'(vga_de), 1);
        end

        // Stall pix_en mid-line: everything must hold.
        run_to(200);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_all();
            chk("pause_fs", int'(frame_start), 0);
        end
        run_to(641);
        chk("blank_de", int'(vga_de), 0);
        chk("blank_rgb", int'({vga_r, vga_g, vga_b}), 0);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        run_to(10 * HT);
        test_mode = 1'b1;
        run_to(10 * HT + 86);
        chk("bar1_r", int'(vga_r), 0);
        chk("bar1_g", int'(vga_g), 0);
        chk("bar1_b", int'(vga_b), 3);
        run_to(12 * HT);
        test_mode = 1'b0;
`endif

        // Rest of the frame and the wrap into the next one.
        run_to(FRAME + 2);
        chk("tbl_visited", idx, 16);
        chk("hs_pulses", hs_pulses, VT);
        chk("vs_pulses", vs_pulses, 1);
        chk("fs_count", fs_count, 1);
        chk("fs_tick", fs_tick, FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
